// File: rtl/choice_capture.sv
// choice_capture: two-player animal selection front end.
// Synchronises the raw key and switches, debounces the key, and captures
// player 1's then player 2's one-hot choice. Both choices are then held with
// choices_valid until the consumer acknowledges them.
module choice_capture #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] sw_choice,
  input  logic       key_n,
  input  logic       ack,
  output logic [2:0] player1_choice,
  output logic [2:0] player2_choice,
  output logic       choices_valid,
  output logic       waiting_p1,
  output logic       waiting_p2,
  output logic       invalid_choice
);

  typedef enum logic [1:0] {
    S_P1    = 2'b00,
    S_P2    = 2'b01,
    S_READY = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser stages.
  logic             kmeta_q, ksync_q;
  logic [2:0]       smeta_q, ssync_q;
  // Debouncer.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_db_q, key_db_d;
  logic             key_db_prev_q;
  // Post-reset arming: a key held through reset must be seen released first.
  logic [1:0]       sync_ok_q;
  logic             armed_q;
  logic             press;
  logic             onehot;
  // FSM and captured data.
  state_t           state_q, state_d;
  logic [2:0]       p1_q, p1_d, p2_q, p2_d;
  logic             inv_q, inv_d;

  // Two-flop synchronisers for the asynchronous key and switch inputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      kmeta_q <= 1'b1;
      ksync_q <= 1'b1;
      smeta_q <= 3'b000;
      ssync_q <= 3'b000;
    end else begin
      kmeta_q <= key_n;
      ksync_q <= kmeta_q;
      smeta_q <= sw_choice;
      ssync_q <= smeta_q;
    end
  end

  // Debounce: accept a new key level only after it differs for DEBOUNCE_CYCLES cycles.
  always_comb begin
    cnt_d    = '0;
    key_db_d = key_db_q;
    if (ksync_q != key_db_q) begin
      if (cnt_q == CNT_LAST) begin
        key_db_d = ksync_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state, edge history and arming flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q         <= '0;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      sync_ok_q     <= 2'b00;
      armed_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      sync_ok_q     <= {sync_ok_q[0], 1'b1};
      if (sync_ok_q == 2'b11 && ksync_q && key_db_q)
        armed_q <= 1'b1;
    end
  end

  assign press  = armed_q & key_db_prev_q & ~key_db_q;
  assign onehot = (ssync_q == 3'b001) || (ssync_q == 3'b010) || (ssync_q == 3'b100);

  // Capture FSM next-state and data logic.
  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    inv_d   = 1'b0;
    case (state_q)
      S_P1: begin
        if (press) begin
          if (onehot) begin
            p1_d    = ssync_q;
            state_d = S_P2;
          end else begin
            inv_d = 1'b1;
          end
        end
      end
      S_P2: begin
        if (press) begin
          if (onehot) begin
            p2_d    = ssync_q;
            state_d = S_READY;
          end else begin
            inv_d = 1'b1;
          end
        end
      end
      S_READY: begin
        if (ack)
          state_d = S_P1;
      end
      default: state_d = S_P1;
    endcase
  end

  // FSM state, captured choices and invalid pulse register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_P1;
      p1_q    <= 3'b000;
      p2_q    <= 3'b000;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      inv_q   <= inv_d;
    end
  end

  assign player1_choice = p1_q;
  assign player2_choice = p2_q;
  assign waiting_p1     = (state_q == S_P1);
  assign waiting_p2     = (state_q == S_P2);
  assign choices_valid  = (state_q == S_READY);
  assign invalid_choice = inv_q;

endmodule

// File: tb/tb_choice_capture.sv
// Directed bench for choice_capture with a short debounce window.
module tb_choice_capture;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] sw_choice;
  logic       key_n;
  logic       ack;
  logic [2:0] player1_choice;
  logic [2:0] player2_choice;
  logic       choices_valid;
  logic       waiting_p1;
  logic       waiting_p2;
  logic       invalid_choice;

  int total = 0;
  int bad   = 0;
  int inv_cnt = 0;
  int inv_base;

  choice_capture #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .sw_choice      (sw_choice),
    .key_n          (key_n),
    .ack            (ack),
    .player1_choice (player1_choice),
    .player2_choice (player2_choice),
    .choices_valid  (choices_valid),
    .waiting_p1     (waiting_p1),
    .waiting_p2     (waiting_p2),
    .invalid_choice (invalid_choice)
  );

  always #5 clk = ~clk;

  // Count cycles in which the invalid pulse is high.
  always @(posedge clk) if (invalid_choice) inv_cnt <= inv_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold the key long enough for one accepted press, then release and settle.
  task automatic press_key;
    key_n = 1'b0;
    repeat (20) tick();
    key_n = 1'b1;
    repeat (20) tick();
  endtask

  initial begin
    resetn = 1'b0; key_n = 1'b1; sw_choice = 3'b000; ack = 1'b0;
    #1;
    // 1: reset
    repeat (3) tick();
    chk("rst_wp1", waiting_p1, 1);
    chk("rst_valid", choices_valid, 0);
    chk("rst_p1", player1_choice, 3'b000);
    chk("rst_p2", player2_choice, 3'b000);
    chk("rst_inv", invalid_choice, 0);
    resetn = 1'b1;
    repeat (5) tick();

    // 2: full round with latency check
    sw_choice = 3'b001;
    repeat (3) tick();
    key_n = 1'b0;
    repeat (6) tick();
    chk("lat_p1_early", player1_choice, 3'b000);
    chk("lat_wp1_early", waiting_p1, 1);
    tick();
    chk("lat_p1", player1_choice, 3'b001);
    chk("lat_wp2", waiting_p2, 1);
    repeat (13) tick();
    key_n = 1'b1;
    repeat (20) tick();
    chk("hold_one_press", waiting_p2, 1);
    sw_choice = 3'b100;
    press_key();
    chk("r2_p2", player2_choice, 3'b100);
    chk("r2_p1", player1_choice, 3'b001);
    chk("r2_valid", choices_valid, 1);
    chk("r2_wp", {waiting_p1, waiting_p2}, 2'b00);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_wp1", waiting_p1, 1);
    chk("ack_valid", choices_valid, 0);
    chk("ack_keep_p2", player2_choice, 3'b100);

    // ack outside S_READY has no effect
    ack = 1'b1;
    repeat (3) tick();
    ack = 1'b0;
    chk("ack_idle", waiting_p1, 1);

    // 3: bounce shorter than the debounce window
    inv_base = inv_cnt;
    sw_choice = 3'b010;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0; repeat (2) tick();
      key_n = 1'b1; repeat (2) tick();
    end
    repeat (10) tick();
    chk("bnc_wp1", waiting_p1, 1);
    chk("bnc_p1", player1_choice, 3'b001);
    chk("bnc_inv", inv_cnt - inv_base, 0);

    // 4: invalid in S_P1, then valid
    inv_base = inv_cnt;
    sw_choice = 3'b011;
    press_key();
    chk("inv1_cnt", inv_cnt - inv_base, 1);
    chk("inv1_wp1", waiting_p1, 1);
    chk("inv1_p1", player1_choice, 3'b001);
    sw_choice = 3'b010;
    press_key();
    chk("p1_010", player1_choice, 3'b010);
    chk("p1_wp2", waiting_p2, 1);
    // invalid in S_P2 keeps player 1
    inv_base = inv_cnt;
    sw_choice = 3'b111;
    press_key();
    chk("inv2_cnt", inv_cnt - inv_base, 1);
    chk("inv2_wp2", waiting_p2, 1);
    chk("inv2_p1", player1_choice, 3'b010);
    inv_base = inv_cnt;
    sw_choice = 3'b000;
    press_key();
    chk("inv3_cnt", inv_cnt - inv_base, 1);
    sw_choice = 3'b001;
    press_key();
    chk("p2_001", player2_choice, 3'b001);
    chk("rdy_valid", choices_valid, 1);

    // 5: ready lock
    sw_choice = 3'b100;
    press_key();
    sw_choice = 3'b010;
    press_key();
    chk("lock_p1", player1_choice, 3'b010);
    chk("lock_p2", player2_choice, 3'b001);
    chk("lock_valid", choices_valid, 1);
    sw_choice = 3'b100;
    repeat (3) tick();
    key_n = 1'b0;
    repeat (6) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ackp_wp1", waiting_p1, 1);
    chk("ackp_p1", player1_choice, 3'b010);
    repeat (13) tick();
    key_n = 1'b1;
    repeat (20) tick();
    chk("ackp_wp1_late", waiting_p1, 1);
    chk("ackp_p1_late", player1_choice, 3'b010);

    // 6: reset mid-capture with key held through release
    press_key();
    chk("pre_rst_wp2", waiting_p2, 1);
    chk("pre_rst_p1", player1_choice, 3'b100);
    key_n = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    chk("mid_rst_wp1", waiting_p1, 1);
    chk("mid_rst_p1", player1_choice, 3'b000);
    chk("mid_rst_p2", player2_choice, 3'b000);
    resetn = 1'b1;
    repeat (20) tick();
    chk("held_nopress_wp1", waiting_p1, 1);
    chk("held_nopress_p1", player1_choice, 3'b000);
    key_n = 1'b1;
    repeat (20) tick();
    chk("held_rel_wp1", waiting_p1, 1);
    sw_choice = 3'b001;
    press_key();
    chk("post_rst_p1", player1_choice, 3'b001);
    chk("post_rst_wp2", waiting_p2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
